// File: rtl/tx_pause_ctrl.sv
// MAC TX pause-frame generator: watches RX FIFO fill, issues XOFF/XON/refresh
// pause frames and arbitrates them against the user TX stream at frame boundaries.
module tx_pause_ctrl #(
    parameter logic [15:0] QUANTA_DEFAULT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        cfg_tx_pause_enable,
    input  logic [15:0] cfg_xoff_thresh,
    input  logic [15:0] cfg_xon_thresh,
    input  logic [15:0] cfg_pause_quanta,
    input  logic [15:0] cfg_refresh_interval,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] rx_fifo_level,
    input  logic        rx_pause_active,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        xoff_state,
    output logic [31:0] pause_frames_sent
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_USER  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        pending_r;
    logic [15:0] pend_quanta_r;
    logic        xoff_r;
    logic [15:0] timer_r;
    logic [2:0]  beat_r;
    logic [15:0] quanta_r;
    logic [47:0] mac_r;
    logic [31:0] count_r;

    logic        xoff_req_s;
    logic        xon_req_s;
    logic        refresh_s;
    logic        start_pause_s;
    logic        beat_adv_s;
    logic        frame_done_s;

    // Beat n carries frame bytes 8n..8n+7, lowest byte in the low lane.
    function automatic logic [63:0] pause_beat(input logic [2:0]  beat,
                                               input logic [47:0] mac,
                                               input logic [15:0] quanta);
        logic [63:0] data;
        case (beat)
            3'd0:    data = {mac[39:32], mac[47:40], 8'h01, 8'h00, 8'h00, 8'hC2, 8'h80, 8'h01};
            3'd1:    data = {8'h01, 8'h00, 8'h08, 8'h88, mac[7:0], mac[15:8], mac[23:16], mac[31:24]};
            3'd2:    data = {48'h0, quanta[7:0], quanta[15:8]};
            default: data = 64'h0;
        endcase
        return data;
    endfunction

    assign xoff_state        = xoff_r;
    assign pause_frames_sent = count_r;

    // Request detection from FIFO level and refresh timer.
    always_comb begin
        xoff_req_s = 1'b0;
        xon_req_s  = 1'b0;
        refresh_s  = 1'b0;
        if (cfg_tx_pause_enable) begin
            xoff_req_s = !xoff_r && (rx_fifo_level >= cfg_xoff_thresh);
            xon_req_s  = xoff_r && (rx_fifo_level <= cfg_xon_thresh);
            refresh_s  = xoff_r && (cfg_refresh_interval != 16'd0) &&
                         (timer_r == (cfg_refresh_interval - 16'd1));
        end else begin
            xoff_req_s = 1'b0;
            xon_req_s  = 1'b0;
            refresh_s  = 1'b0;
        end
    end

    // Pending request, XOFF state and refresh timer; XON outranks refresh.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pending_r     <= 1'b0;
            pend_quanta_r <= QUANTA_DEFAULT;
            xoff_r        <= 1'b0;
            timer_r       <= 16'd0;
        end else if (!cfg_tx_pause_enable) begin
            pending_r <= 1'b0;
            xoff_r    <= 1'b0;
            timer_r   <= 16'd0;
        end else if (xon_req_s) begin
            pending_r     <= 1'b1;
            pend_quanta_r <= 16'h0000;
            xoff_r        <= 1'b0;
            timer_r       <= 16'd0;
        end else if (xoff_req_s) begin
            pending_r     <= 1'b1;
            pend_quanta_r <= cfg_pause_quanta;
            xoff_r        <= 1'b1;
            timer_r       <= 16'd0;
        end else if (refresh_s) begin
            pending_r     <= 1'b1;
            pend_quanta_r <= cfg_pause_quanta;
            timer_r       <= 16'd0;
        end else begin
            if (start_pause_s) begin
                pending_r <= 1'b0;
            end
            if (xoff_r && (cfg_refresh_interval != 16'd0)) begin
                timer_r <= timer_r + 16'd1;
            end else begin
                timer_r <= 16'd0;
            end
        end
    end

    // Frame-boundary arbitration and output muxing.
    always_comb begin
        state_nxt_s   = state_r;
        start_pause_s = 1'b0;
        beat_adv_s    = 1'b0;
        frame_done_s  = 1'b0;
        m_axis_tdata  = 64'h0;
        m_axis_tkeep  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r && cfg_tx_pause_enable) begin
                    state_nxt_s   = ST_PAUSE;
                    start_pause_s = 1'b1;
                end else if (s_axis_tvalid && !rx_pause_active) begin
                    state_nxt_s = ST_USER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_USER: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_USER;
                end
            end
            ST_PAUSE: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = pause_beat(beat_r, mac_r, quanta_r);
                m_axis_tkeep  = (beat_r == 3'd7) ? 8'h0F : 8'hFF;
                m_axis_tlast  = (beat_r == 3'd7);
                if (m_axis_tready) begin
                    beat_adv_s = 1'b1;
                    if (beat_r == 3'd7) begin
                        frame_done_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, beat counter, frame snapshot and sent-frame counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            beat_r   <= 3'd0;
            quanta_r <= QUANTA_DEFAULT;
            mac_r    <= 48'h0;
            count_r  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (start_pause_s) begin
                beat_r   <= 3'd0;
                quanta_r <= pend_quanta_r;
                mac_r    <= cfg_src_mac;
            end else if (beat_adv_s) begin
                beat_r <= beat_r + 3'd1;
            end else begin
                beat_r <= beat_r;
            end
            if (frame_done_s) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_tx_pause_ctrl.sv
// Self-checking bench for tx_pause_ctrl: random MAC/quanta/data checked against
// a byte-level frame model and arithmetic timing expectations.
`timescale 1ns/1ps
module tb_tx_pause_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cfg_tx_pause_enable;
    logic [15:0] cfg_xoff_thresh, cfg_xon_thresh, cfg_pause_quanta, cfg_refresh_interval;
    logic [47:0] cfg_src_mac;
    logic [15:0] rx_fifo_level;
    logic        rx_pause_active;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic        xoff_state;
    logic [31:0] pause_frames_sent;

    always #5 clk = ~clk;

    tx_pause_ctrl dut (
        .clk(clk), .aresetn(aresetn), .cfg_tx_pause_enable(cfg_tx_pause_enable),
        .cfg_xoff_thresh(cfg_xoff_thresh), .cfg_xon_thresh(cfg_xon_thresh),
        .cfg_pause_quanta(cfg_pause_quanta), .cfg_refresh_interval(cfg_refresh_interval),
        .cfg_src_mac(cfg_src_mac), .rx_fifo_level(rx_fifo_level), .rx_pause_active(rx_pause_active),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .xoff_state(xoff_state), .pause_frames_sent(pause_frames_sent)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_count = 0;

    logic [7:0] rx_bytes[$];
    int         rx_lens[$], rx_beats[$], rx_start[$], rx_end[$];
    logic [7:0] rx_lkeep[$];
    int         tlast_cnt = 0;
    logic [7:0] exp_user[$];

    int         f_len, f_beats, f_start, f_end;
    logic [7:0] f_lkeep;
    logic [7:0] fb [0:127];

    // Reference frame: byte n of a pause frame, straight from the frame layout table.
    function automatic logic [7:0] pause_byte(input int n, input logic [47:0] mac, input logic [15:0] q);
        case (n)
            0: return 8'h01;  1: return 8'h80;  2: return 8'hC2;
            3: return 8'h00;  4: return 8'h00;  5: return 8'h01;
            6, 7, 8, 9, 10, 11: return mac[8*(11-n) +: 8];
            12: return 8'h88; 13: return 8'h08; 14: return 8'h00; 15: return 8'h01;
            16: return q[15:8];
            17: return q[7:0];
            default: return 8'h00;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: gathers accepted bytes into frames; reset drops a partial frame.
    initial begin : monitor
        logic [7:0] cur[$];
        int cur_beats, cur_start;
        cur_beats = 0;
        cur_start = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                cur.delete();
                cur_beats = 0;
            end else if (m_axis_tvalid && m_axis_tready) begin
                if (cur_beats == 0) cur_start = cyc;
                for (int i = 0; i < 8; i++)
                    if (m_axis_tkeep[i]) cur.push_back(m_axis_tdata[8*i +: 8]);
                cur_beats++;
                if (m_axis_tlast) begin
                    rx_lens.push_back(cur.size());
                    foreach (cur[i]) rx_bytes.push_back(cur[i]);
                    rx_beats.push_back(cur_beats);
                    rx_lkeep.push_back(m_axis_tkeep);
                    rx_start.push_back(cur_start);
                    rx_end.push_back(cyc);
                    tlast_cnt++;
                    cur.delete();
                    cur_beats = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic get_frame(input int budget, output bit got);
        int w;
        logic [7:0] b;
        w = 0;
        while (rx_lens.size() == 0 && w < budget) begin
            tick(1);
            w++;
        end
        got = (rx_lens.size() != 0);
        if (got) begin
            f_len   = rx_lens.pop_front();
            f_beats = rx_beats.pop_front();
            f_lkeep = rx_lkeep.pop_front();
            f_start = rx_start.pop_front();
            f_end   = rx_end.pop_front();
            for (int i = 0; i < f_len; i++) begin
                b = rx_bytes.pop_front();
                if (i < 128) fb[i] = b;
            end
        end
    endtask

    task automatic send_user(input int nb, output bit ok);
        bit hs;
        int w;
        ok = 1'b1;
        for (int b = 0; b < nb; b++) begin
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tvalid = 1'b1;
            for (int i = 0; i < 8; i++) exp_user.push_back(s_axis_tdata[8*i +: 8]);
            hs = 1'b0;
            w  = 0;
            while (!hs && w < 400) begin
                @(negedge clk);
                hs = s_axis_tready;
                tick(1);
                w++;
            end
            if (!hs) begin
                ok = 1'b0;
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        cfg_tx_pause_enable = 1'b1;
        rx_fifo_level = 16'd500;
        s_axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %b want 0", m_axis_tvalid); end
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_sready: got %b want 0", s_axis_tready); end
        n_checks++; if (xoff_state !== 1'b0) begin n_fail++; $display("FAIL rst_xoff: got %b want 0", xoff_state); end
        n_checks++; if (pause_frames_sent !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", pause_frames_sent); end
        tick(1);
        s_axis_tvalid = 1'b0;
        cfg_tx_pause_enable = 1'b0;
        rx_fifo_level = 16'd0;
        aresetn = 1'b1;
        tick(3);
        n_checks++; if (m_axis_tvalid !== 1'b0 || xoff_state !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: mvalid %b xoff %b want 0 0", m_axis_tvalid, xoff_state); end
    endtask

    task automatic test_xoff();
        bit got;
        int bad;
        logic [47:0] mac;
        mac = {16'($urandom), 32'($urandom)};
        cfg_src_mac = mac;
        cfg_xoff_thresh = 16'd100;
        cfg_xon_thresh = 16'd20;
        cfg_pause_quanta = 16'h0200;
        cfg_refresh_interval = 16'd0;
        rx_fifo_level = 16'd99;
        cfg_tx_pause_enable = 1'b1;
        tick(20);
        n_checks++; if (rx_lens.size() != 0 || xoff_state !== 1'b0) begin n_fail++; $display("FAIL below_xoff: frames %0d xoff %b want 0 0", rx_lens.size(), xoff_state); end
        rx_fifo_level = 16'd100;
        get_frame(50, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL xoff_timeout: no frame want 1"); end
        if (got) begin
            exp_count++;
            bad = 0;
            for (int i = 0; i < 60; i++) if (fb[i] !== pause_byte(i, mac, 16'h0200)) bad++;
            n_checks++; if (f_len != 60 || f_beats != 8 || f_lkeep !== 8'h0F || bad != 0) begin n_fail++; $display("FAIL xoff_frame: len %0d beats %0d lastkeep %h badbytes %0d want 60 8 0f 0", f_len, f_beats, f_lkeep, bad); end
            n_checks++; if ({fb[16], fb[17]} !== 16'h0200) begin n_fail++; $display("FAIL xoff_quanta: got %h want 0200", {fb[16], fb[17]}); end
        end
        rx_fifo_level = 16'd50;
        tick(2);
        n_checks++; if (xoff_state !== 1'b1) begin n_fail++; $display("FAIL xoff_state: got %b want 1", xoff_state); end
        n_checks++; if (pause_frames_sent !== 32'(exp_count)) begin n_fail++; $display("FAIL xoff_count: got %0d want %0d", pause_frames_sent, exp_count); end
    endtask

    task automatic test_xon();
        bit got;
        int bad;
        rx_fifo_level = 16'd21;
        tick(10);
        n_checks++; if (rx_lens.size() != 0 || xoff_state !== 1'b1) begin n_fail++; $display("FAIL above_xon: frames %0d xoff %b want 0 1", rx_lens.size(), xoff_state); end
        rx_fifo_level = 16'd20;
        get_frame(50, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL xon_timeout: no frame want 1"); end
        if (got) begin
            exp_count++;
            bad = 0;
            for (int i = 0; i < 60; i++) if (fb[i] !== pause_byte(i, cfg_src_mac, 16'h0000)) bad++;
            n_checks++; if (f_len != 60 || f_lkeep !== 8'h0F || bad != 0) begin n_fail++; $display("FAIL xon_frame: len %0d lastkeep %h badbytes %0d want 60 0f 0", f_len, f_lkeep, bad); end
        end
        rx_fifo_level = 16'd50;
        tick(1);
        n_checks++; if (xoff_state !== 1'b0 || pause_frames_sent !== 32'(exp_count)) begin n_fail++; $display("FAIL xon_state: xoff %b count %0d want 0 %0d", xoff_state, pause_frames_sent, exp_count); end
    endtask

    task automatic test_disable();
        bit got;
        rx_fifo_level = 16'd200;
        get_frame(50, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL dis_xoff_timeout: no frame want 1"); end
        if (got) exp_count++;
        cfg_tx_pause_enable = 1'b0;
        tick(1);
        n_checks++; if (xoff_state !== 1'b0) begin n_fail++; $display("FAIL dis_xoff_clear: got %b want 0", xoff_state); end
        tick(30);
        n_checks++; if (rx_lens.size() != 0 || pause_frames_sent !== 32'(exp_count)) begin n_fail++; $display("FAIL dis_quiet: frames %0d count %0d want 0 %0d", rx_lens.size(), pause_frames_sent, exp_count); end
        rx_fifo_level = 16'd50;
        cfg_tx_pause_enable = 1'b1;
        tick(2);
    endtask

    task automatic test_refresh();
        bit got;
        int bad, s_prev;
        logic [15:0] q;
        q = 16'($urandom);
        cfg_pause_quanta = q;
        cfg_refresh_interval = 16'd1000;
        rx_fifo_level = 16'd150;
        s_prev = 0;
        for (int k = 0; k < 3; k++) begin
            get_frame(1100, got);
            n_checks++; if (!got) begin n_fail++; $display("FAIL refresh_timeout: frame %0d missing", k); end
            if (got) begin
                exp_count++;
                bad = 0;
                for (int i = 0; i < 60; i++) if (fb[i] !== pause_byte(i, cfg_src_mac, q)) bad++;
                n_checks++; if (f_len != 60 || bad != 0) begin n_fail++; $display("FAIL refresh_frame%0d: len %0d badbytes %0d want 60 0", k, f_len, bad); end
                if (k > 0) begin
                    n_checks++; if (f_start - s_prev != 1000) begin n_fail++; $display("FAIL refresh_spacing: got %0d want 1000", f_start - s_prev); end
                end
                s_prev = f_start;
                tick(1);
                n_checks++; if (pause_frames_sent !== 32'(exp_count)) begin n_fail++; $display("FAIL refresh_count: got %0d want %0d", pause_frames_sent, exp_count); end
            end
        end
        cfg_refresh_interval = 16'd0;
        tick(1200);
        n_checks++; if (rx_lens.size() != 0) begin n_fail++; $display("FAIL refresh_off: frames %0d want 0", rx_lens.size()); end
        rx_fifo_level = 16'd10;
        get_frame(50, got);
        if (got) exp_count++;
        rx_fifo_level = 16'd50;
        tick(1);
        n_checks++; if (!got || xoff_state !== 1'b0) begin n_fail++; $display("FAIL refresh_xon: got %b xoff %b want 1 0", got, xoff_state); end
    endtask

    task automatic test_user_then_pause();
        bit ok, got;
        int bad, uend;
        logic [15:0] q;
        q = 16'($urandom);
        cfg_pause_quanta = q;
        exp_user.delete();
        uend = 0;
        fork
            send_user(10, ok);
            begin tick(3); rx_fifo_level = 16'd200; end
        join
        n_checks++; if (!ok) begin n_fail++; $display("FAIL user_hs_timeout: user frame stalled"); end
        get_frame(50, got);
        bad = 0;
        if (got) begin
            for (int i = 0; i < f_len && i < exp_user.size(); i++) if (fb[i] !== exp_user[i]) bad++;
            uend = f_end;
        end
        n_checks++; if (!got || f_len != 80 || bad != 0) begin n_fail++; $display("FAIL user_frame: got %b len %0d badbytes %0d want 1 80 0", got, f_len, bad); end
        get_frame(50, got);
        if (got) begin
            exp_count++;
            bad = 0;
            for (int i = 0; i < 60; i++) if (fb[i] !== pause_byte(i, cfg_src_mac, q)) bad++;
        end
        n_checks++; if (!got || f_len != 60 || bad != 0) begin n_fail++; $display("FAIL follow_pause: got %b len %0d badbytes %0d want 1 60 0", got, f_len, bad); end
        n_checks++; if (f_start - uend > 2) begin n_fail++; $display("FAIL follow_gap: got %0d cycles want <=2", f_start - uend); end
        rx_fifo_level = 16'd10;
        get_frame(50, got);
        if (got) exp_count++;
        rx_fifo_level = 16'd50;
        tick(1);
        n_checks++; if (pause_frames_sent !== 32'(exp_count)) begin n_fail++; $display("FAIL user_count: got %0d want %0d", pause_frames_sent, exp_count); end
    endtask

    task automatic test_rx_pause();
        bit ok, got;
        int bad, viol, nf;
        logic [15:0] q;
        q = 16'($urandom);
        cfg_pause_quanta = q;
        exp_user.delete();
        rx_pause_active = 1'b1;
        viol = 0;
        nf = 0;
        fork
            send_user(4, ok);
            begin
                tick(2);
                rx_fifo_level = 16'd200;
                repeat (60) begin
                    @(negedge clk);
                    if (s_axis_tready) viol++;
                end
                tick(1);
                nf = rx_lens.size();
                rx_pause_active = 1'b0;
            end
        join
        n_checks++; if (viol != 0 || nf != 1) begin n_fail++; $display("FAIL rxpause_hold: tready cycles %0d frames %0d want 0 1", viol, nf); end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rxpause_user_timeout: user frame stalled"); end
        get_frame(50, got);
        bad = 0;
        if (got) for (int i = 0; i < 60; i++) if (fb[i] !== pause_byte(i, cfg_src_mac, q)) bad++;
        if (got) exp_count++;
        n_checks++; if (!got || f_len != 60 || bad != 0) begin n_fail++; $display("FAIL rxpause_pause: got %b len %0d badbytes %0d want 1 60 0", got, f_len, bad); end
        get_frame(50, got);
        bad = 0;
        if (got) for (int i = 0; i < f_len && i < exp_user.size(); i++) if (fb[i] !== exp_user[i]) bad++;
        n_checks++; if (!got || f_len != 32 || bad != 0) begin n_fail++; $display("FAIL rxpause_user: got %b len %0d badbytes %0d want 1 32 0", got, f_len, bad); end
        rx_fifo_level = 16'd10;
        get_frame(50, got);
        if (got) exp_count++;
        rx_fifo_level = 16'd50;
        tick(1);
    endtask

    task automatic test_backpressure_reset();
        bit got;
        int bad, stalls, done, hs, w, tl0;
        bit prev_stall;
        logic [73:0] prev_bus;
        logic [47:0] mac;
        logic [15:0] q;
        mac = {16'($urandom), 32'($urandom)};
        q = 16'($urandom);
        cfg_src_mac = mac;
        cfg_pause_quanta = q;
        cfg_refresh_interval = 16'd40;
        tl0 = tlast_cnt;
        bad = 0; stalls = 0; done = 0; hs = 0; w = 0;
        prev_stall = 1'b0;
        prev_bus = '0;
        rx_fifo_level = 16'd200;
        while (!(done == 1 && hs == 4) && w < 600) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                stalls++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== prev_bus) bad++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_bus = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) begin
                if (m_axis_tlast) begin done++; hs = 0; end else hs++;
            end
            tick(1);
            w++;
        end
        n_checks++; if (w >= 600) begin n_fail++; $display("FAIL bp_timeout: frames %0d beats %0d want 1 4", done, hs); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall_stable: changed %0d of %0d stalls want 0", bad, stalls); end
        get_frame(1, got);
        bad = 0;
        if (got) for (int i = 0; i < 60; i++) if (fb[i] !== pause_byte(i, mac, q)) bad++;
        n_checks++; if (!got || f_len != 60 || f_lkeep !== 8'h0F || bad != 0) begin n_fail++; $display("FAIL bp_frame: got %b len %0d lastkeep %h badbytes %0d want 1 60 0f 0", got, f_len, f_lkeep, bad); end
        aresetn = 1'b0;
        #2;
        n_checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_outs: valid %b last %b sready %b want 0 0 0", m_axis_tvalid, m_axis_tlast, s_axis_tready); end
        n_checks++; if (xoff_state !== 1'b0 || pause_frames_sent !== 32'd0) begin n_fail++; $display("FAIL midrst_state: xoff %b count %0d want 0 0", xoff_state, pause_frames_sent); end
        exp_count = 0;
        rx_fifo_level = 16'd50;
        m_axis_tready = 1'b1;
        tick(3);
        aresetn = 1'b1;
        tick(20);
        n_checks++; if (rx_lens.size() != 0 || tlast_cnt != tl0 + 1 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_quiet: frames %0d tlasts %0d valid %b want 0 %0d 0", rx_lens.size(), tlast_cnt - tl0, m_axis_tvalid, 1); end
        n_checks++; if (xoff_state !== 1'b0 || pause_frames_sent !== 32'(exp_count)) begin n_fail++; $display("FAIL post_rst_state: xoff %b count %0d want 0 0", xoff_state, pause_frames_sent); end
    endtask

    initial begin
        aresetn = 1'b0;
        cfg_tx_pause_enable = 1'b0;
        cfg_xoff_thresh = 16'd100;
        cfg_xon_thresh = 16'd20;
        cfg_pause_quanta = 16'h0200;
        cfg_refresh_interval = 16'd0;
        cfg_src_mac = 48'h0;
        rx_fifo_level = 16'd0;
        rx_pause_active = 1'b0;
        s_axis_tdata = 64'h0;
        s_axis_tkeep = 8'hFF;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        tick(1);
        test_reset();
        test_xoff();
        test_xon();
        test_disable();
        test_refresh();
        test_user_then_pause();
        test_rx_pause();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_pause_ctrl.md
TX_PAUSE_CTRL -- requirements
Module: tx_pause_ctrl

Interface
REQ-001 Parameter QUANTA_DEFAULT, 16'hFFFF: reset value of the internal quanta register.
REQ-002 clk  in  1  sole clock; every register uses rising edge.
REQ-003 aresetn  in  1  reset, asynchronous, active-low.
REQ-004 cfg_tx_pause_enable  in  1  enables pause-frame generation.
REQ-005 cfg_xoff_thresh, cfg_xon_thresh  in  16 each  RX FIFO fill thresholds, in words.
REQ-006 cfg_pause_quanta  in  16  quanta carried by XOFF frames.
REQ-007 cfg_refresh_interval  in  16  clk cycles between XOFF refreshes.
REQ-008 cfg_src_mac  in  48  SA of generated frames, byte 0 in [47:40].
REQ-009 rx_fifo_level  in  16  current RX FIFO occupancy.
REQ-010 rx_pause_active  in  1  link partner has paused us.
REQ-011 s_axis_tdata/tkeep/tvalid/tlast  in  64/8/1/1  user TX stream; s_axis_tready  out  1.
REQ-012 m_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  stream to MAC TX; m_axis_tready  in  1.
REQ-013 xoff_state  out  1  XOFF is in force toward the partner.
REQ-014 pause_frames_sent  out  32  count of generated frames; wraps.

Function
REQ-015 The FSM SHALL have three states: IDLE (frame boundary), USER (forwarding), PAUSE (emitting a frame).
REQ-016 XOFF request: cfg_tx_pause_enable && !xoff_state && rx_fifo_level >= cfg_xoff_thresh -> set pending, pending quanta = cfg_pause_quanta, xoff_state <= 1.
REQ-017 XON request: xoff_state && rx_fifo_level <= cfg_xon_thresh -> set pending, pending quanta = 0, xoff_state <= 0.
REQ-018 Refresh: while xoff_state, a 16-bit timer counts each cycle; at cfg_refresh_interval-1 it reloads 0 and sets pending with cfg_pause_quanta.
REQ-019 XON and refresh in the same cycle: XON wins; the timer is cleared.
REQ-020 A new request while one is pending overwrites the pending quanta; at most one frame is pending.
REQ-021 IDLE: if pending, go to PAUSE, latch quanta, clear pending, beat=0; pause has priority over user.
REQ-022 IDLE, no pending, s_axis_tvalid && !rx_pause_active: go to USER. s_axis_tready=0 in IDLE.
REQ-023 USER: m_axis_* = s_axis_* and s_axis_tready = m_axis_tready, both combinational. Go to IDLE on a handshake with tlast.
REQ-024 rx_pause_active is evaluated only in IDLE. A frame already started completes.
REQ-025 PAUSE SHALL emit 8 beats, byte n on tdata[8n+7:8n]. Beats 0-6 have tkeep=FF. Beat 7 has tkeep=0F and tlast=1, giving 60 bytes; FCS is appended downstream.
REQ-026 Frame content: bytes 0-5 DA 01 80 C2 00 00 01; bytes 6-11 cfg_src_mac; bytes 12-13 88 08; bytes 14-15 00 01; bytes 16-17 quanta MSB first; all remaining bytes 00.
REQ-027 PAUSE: m_axis_tvalid=1; beat advances only on m_axis_tready; data is held stable while stalled.
REQ-028 On the final-beat handshake: pause_frames_sent increments mod 2^32, FSM returns to IDLE.
REQ-029 m_axis_tvalid=0 in IDLE.
REQ-030 cfg_tx_pause_enable=0 SHALL clear pending, xoff_state and the timer within one cycle. A PAUSE frame in progress completes unchanged.
REQ-031 cfg_refresh_interval=0 disables refresh.

Reset
REQ-032 aresetn low SHALL asynchronously force: state IDLE, pending 0, xoff_state 0, timer 0, beat 0, quanta QUANTA_DEFAULT, pause_frames_sent 0, m_axis_tvalid 0, s_axis_tready 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no tlast emitted. After deassertion the block resumes from IDLE with no stale request.

Verification
REQ-034 xoff_thresh=100, level 99->100, pause_quanta=16'h0200, tready=1 -> 8 beats; beat 2 bytes 16-17 = 02 00; beat 7 tkeep=0F, tlast=1; xoff_state=1; pause_frames_sent=1.
REQ-035 xoff_state=1, xon_thresh=20, level drops to 20 -> frame with quanta 0000; xoff_state=0.
REQ-036 refresh_interval=1000, level held above xoff_thresh -> XOFF frames start 1000 cycles apart (+/- the IDLE wait); count increments each frame.
REQ-037 User 10-beat frame in flight when XOFF triggers -> user frame completes intact, then the pause frame follows with no idle gap beyond 1 cycle.
REQ-038 rx_pause_active=1 with user frame waiting and an XOFF pending -> pause frame sent, s_axis_tready stays 0; deassert -> user frame forwarded.
REQ-039 Random m_axis_tready backpressure during PAUSE, then aresetn pulse at beat 4 -> data stable while stalled; after reset all outputs at reset values and no tlast emitted.
